// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder backed by a NUM_REGS x DATA_WIDTH register file.
// Independent write (AW/W in any order) and read FSMs; out-of-range accesses answer SLVERR.
module axi4_lite_slave_regs #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ADDR_LSB   = 0
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_ready_c, w_ready_c, ar_ready_c;
  logic                  wr_en, aw_latch, w_latch, rd_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;

  // Any address bit above the index field makes the access out of range.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a >> ADDR_LSB) < ADDR_WIDTH'(NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> ADDR_LSB);
  endfunction

  // Readies are blanked combinationally for as long as reset is held.
  assign AWREADY = aw_ready_c & ~ARESET;
  assign WREADY  = w_ready_c  & ~ARESET;
  assign ARREADY = ar_ready_c & ~ARESET;
  assign BVALID  = (w_state == W_RESP);
  assign RVALID  = (r_state == R_RESP);

  // Whichever half arrives last comes straight from the bus, the other from its latch.
  assign wr_addr = (w_state == W_WAIT_W)  ? aw_addr_q : AWADDR;
  assign wr_data = (w_state == W_WAIT_AW) ? w_data_q  : WDATA;
  assign wr_strb = (w_state == W_WAIT_AW) ? w_strb_q  : WSTRB;

  always_comb begin
    w_state_n  = w_state;
    aw_ready_c = 1'b0;
    w_ready_c  = 1'b0;
    wr_en      = 1'b0;
    aw_latch   = 1'b0;
    w_latch    = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_ready_c = 1'b1;
        w_ready_c  = 1'b1;
        if (AWVALID && WVALID) begin
          wr_en     = 1'b1;
          w_state_n = W_RESP;
        end else if (AWVALID) begin
          aw_latch  = 1'b1;
          w_state_n = W_WAIT_W;
        end else if (WVALID) begin
          w_latch   = 1'b1;
          w_state_n = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        w_ready_c = 1'b1;
        if (WVALID) begin
          wr_en     = 1'b1;
          w_state_n = W_RESP;
        end
      end
      W_WAIT_AW: begin
        aw_ready_c = 1'b1;
        if (AWVALID) begin
          wr_en     = 1'b1;
          w_state_n = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      BRESP     <= RESP_OKAY;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      w_state <= w_state_n;
      if (aw_latch) aw_addr_q <= AWADDR;
      if (w_latch) begin
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (wr_en) begin
        BRESP <= addr_ok(wr_addr) ? RESP_OKAY : RESP_SLVERR;
        if (addr_ok(wr_addr)) begin
          for (int b = 0; b < int'(STRB_W); b++) begin
            if (wr_strb[b]) regs[addr_idx(wr_addr)][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    r_state_n  = r_state;
    ar_ready_c = 1'b0;
    rd_en      = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_ready_c = 1'b1;
        if (ARVALID) begin
          rd_en     = 1'b1;
          r_state_n = R_RESP;
        end
      end
      R_RESP: begin
        if (RREADY) r_state_n = R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // Read data samples the register file before any same-edge write lands.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      r_state <= r_state_n;
      if (rd_en) begin
        RDATA <= addr_ok(ARADDR) ? regs[addr_idx(ARADDR)] : '0;
        RRESP <= addr_ok(ARADDR) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule
